// File: rtl/ice51_uart_loader.sv
// ice51 serial boot loader: 8N1 UART receiver that streams bytes
// into program memory from address 0 and flags done when full.
module ice51_uart_loader #(
  parameter int CLK_PER_BIT = 104,
  parameter int MEM_SIZE    = 512,
  parameter int ADDR_W      = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_uart_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_done,
  output logic              o_frame_err
);

  localparam int BW = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0] FULL = BW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] HALF = BW'(CLK_PER_BIT / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, DONE
  } state_t;

  state_t            state, state_n;
  logic              rx_m, rx_s;
  logic [2:0]        bit_cnt, bit_n;
  logic [BW-1:0]     baud, baud_n;
  logic [7:0]        shift, shift_n;
  logic              brk, brk_n;
  logic              we_n, done_n, ferr_n;
  logic [7:0]        wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic              tick;

  assign tick = (baud == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      baud        <= '0;
      shift       <= '0;
      brk         <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_m        <= i_uart_rx;
      rx_s        <= rx_m;
      state       <= state_n;
      bit_cnt     <= bit_n;
      baud        <= baud_n;
      shift       <= shift_n;
      brk         <= brk_n;
      o_mem_we    <= we_n;
      o_mem_addr  <= addr_n;
      o_mem_wdata <= wdata_n;
      o_done      <= done_n;
      o_frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    baud_n  = baud;
    shift_n = shift;
    brk_n   = brk;
    we_n    = 1'b0;
    wdata_n = o_mem_wdata;
    done_n  = o_done;
    ferr_n  = o_frame_err;
    addr_n  = o_mem_addr;
    // address advances after the write strobe, holding at the last slot
    if (o_mem_we && !o_done)
      addr_n = o_mem_addr + ADDR_W'(1);
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          baud_n  = HALF;
        end
      end
      START: begin
        if (!tick) begin
          baud_n = baud - BW'(1);
        end else if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          bit_n   = '0;
          baud_n  = FULL;
        end
      end
      DATA: begin
        if (!tick) begin
          baud_n = baud - BW'(1);
        end else begin
          shift_n[bit_cnt] = rx_s;
          baud_n = FULL;
          if (bit_cnt == 3'd7)
            state_n = STOP;
          else
            bit_n = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        // after a low stop bit, wait out the break before re-arming
        if (brk) begin
          if (rx_s) begin
            brk_n   = 1'b0;
            state_n = IDLE;
          end
        end else if (!tick) begin
          baud_n = baud - BW'(1);
        end else if (rx_s) begin
          we_n    = 1'b1;
          wdata_n = shift;
          if (o_mem_addr == LAST) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          ferr_n = 1'b1;
          brk_n  = 1'b1;
        end
      end
      DONE: ;
      default: state_n = IDLE;
    endcase
  end

endmodule
